clk_sel_sequencer: RTL and testbench

//  Producer of the select input for the glitch-free 2:1 clock switch (clkSwitch2to1 io_clksel).

---
 rtl/clk_sel_pkg.sv | 15 +
 rtl/clk_sel_timer.sv | 26 ++
 rtl/clk_sel_sequencer.sv | 119 +++++++++++
 tb/tb_clk_sel_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// Shared types and default timing constants for the clock-select sequencer.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    HOLD   = 2'd2
  } clk_sel_state_t;

  localparam int unsigned DEF_SETTLE_CYC  = 8;
  localparam int unsigned DEF_DWELL_CYC   = 64;
  localparam int unsigned DEF_AUTO_PERIOD = 128;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/clk_sel_timer.sv
// Down-counter shared by the settle and dwell phases; parks at zero.
module clk_sel_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk0) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_sel_sequencer.sv
// Drives the select of a glitch-free 2:1 clock switch: handshake or periodic
// auto requests, a settle window, then a minimum dwell before the next change.
module clk_sel_sequencer
  import clk_sel_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned DWELL_CYC   = DEF_DWELL_CYC,
  parameter int unsigned AUTO_PERIOD = DEF_AUTO_PERIOD,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             auto_en,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  output logic             clksel,
  output logic             cur_sel,
  output logic             busy,
  output logic             done,
  output logic             drop,
  output logic [CNT_W-1:0] switch_cnt
);

  clk_sel_state_t   state_q;
  logic             clksel_q, cur_sel_q, busy_q, done_q, drop_q;
  logic [CNT_W-1:0] auto_cnt_q, switch_cnt_q;

  logic             accept, auto_fire, start_sw, next_sel;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  assign req_ready = (state_q == IDLE) && !auto_en;
  assign accept    = req_valid && req_ready;
  assign auto_fire = (state_q == IDLE) && auto_en &&
                     (auto_cnt_q == CNT_W'(AUTO_PERIOD - 1));
  // accept and auto_fire are mutually exclusive since auto_en blocks req_ready
  assign start_sw  = (accept && (req_sel != clksel_q)) || auto_fire;
  assign next_sel  = auto_fire ? ~clksel_q : req_sel;

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    if (start_sw) begin
      tmr_load     = 1'b1;
      tmr_load_val = CNT_W'(SETTLE_CYC - 1);
    end else if ((state_q == SWITCH) && tmr_zero) begin
      tmr_load     = 1'b1;
      tmr_load_val = CNT_W'(DWELL_CYC - 1);
    end
  end

  clk_sel_timer #(.CNT_W(CNT_W)) u_timer (
    .clk0     (clk0),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q      <= IDLE;
      clksel_q     <= 1'b0;
      cur_sel_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
      auto_cnt_q   <= '0;
      switch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= req_valid && !req_ready;

      if ((state_q == IDLE) && auto_en && !auto_fire) begin
        auto_cnt_q <= auto_cnt_q + 1'b1;
      end else begin
        auto_cnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start_sw) begin
            clksel_q <= next_sel;
            state_q  <= SWITCH;
            busy_q   <= 1'b1;
            if (switch_cnt_q != '1) begin
              switch_cnt_q <= switch_cnt_q + 1'b1;
            end
          end else if (accept) begin
            done_q <= 1'b1;
          end
        end
        SWITCH: begin
          if (tmr_zero) begin
            state_q   <= HOLD;
            cur_sel_q <= clksel_q;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clksel     = clksel_q;
  assign cur_sel    = cur_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign drop       = drop_q;
  assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Directed bench for clk_sel_sequencer with short settle/dwell/auto timings.
module tb_clk_sel_sequencer;

  localparam int CNT_W = 16;

  logic             clk0 = 1'b0;
  logic             rst = 1'b1;
  logic             auto_en = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_sel = 1'b0;
  logic             req_ready, clksel, cur_sel, busy, done, drop;
  logic [CNT_W-1:0] switch_cnt;

  int tests = 0;
  int fails = 0;

  clk_sel_sequencer #(
    .SETTLE_CYC  (4),
    .DWELL_CYC   (8),
    .AUTO_PERIOD (16),
    .CNT_W       (CNT_W)
  ) dut (
    .clk0       (clk0),
    .rst        (rst),
    .auto_en    (auto_en),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .clksel     (clksel),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .done       (done),
    .drop       (drop),
    .switch_cnt (switch_cnt)
  );

  always #5 clk0 = ~clk0;

  // advance one edge; sample and drive 1 ns later
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_sel = 1'b1; auto_en = 1'b0;
    repeat (5) tick();
    tests++; if (clksel !== 1'b0) begin fails++; $display("FAIL reset_clksel got=%b exp=0", clksel); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (switch_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", switch_cnt); end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    $display("[TB] reset: clksel=%b busy=%b cnt=%0d ready=%b", clksel, busy, switch_cnt, req_ready);
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    tests++; if (clksel !== 1'b1 || busy !== 1'b1 || cur_sel !== 1'b0) begin
      fails++; $display("FAIL single_accept got clksel=%b busy=%b cur_sel=%b exp 1 1 0", clksel, busy, cur_sel); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      tests++; if (cur_sel !== (i >= 4)) begin fails++; $display("FAIL single_cur_sel k+%0d got=%b exp=%b", i, cur_sel, i >= 4); end
      tests++; if (busy !== (i < 12)) begin fails++; $display("FAIL single_busy k+%0d got=%b exp=%b", i, busy, i < 12); end
      tests++; if (done !== (i == 12)) begin fails++; $display("FAIL single_done k+%0d got=%b exp=%b", i, done, i == 12); end
    end
    tests++; if (switch_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt got=%0d exp=1", switch_cnt); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width got=%b exp=0", done); end
    $display("[TB] single switch: clksel=%b cur_sel=%b cnt=%0d", clksel, cur_sel, switch_cnt);
  endtask

  task automatic test_same_sel();
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL same_done got=%b exp=1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL same_busy got=%b exp=0", busy); end
    tests++; if (switch_cnt !== 16'd1 || clksel !== 1'b1) begin
      fails++; $display("FAIL same_state got cnt=%0d clksel=%b exp 1 1", switch_cnt, clksel); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL same_done_width got=%b exp=0", done); end
    $display("[TB] same-select: cnt=%0d busy=%b", switch_cnt, busy);
  endtask

  task automatic test_busy_drop();
    int drops = 0;
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    req_valid = 1'b1; req_sel = 1'b1;
    for (int i = 6; i <= 16; i++) begin
      tick();
      if (i == 8) req_valid = 1'b0;
      if (drop === 1'b1) drops++;
      tests++; if (clksel !== 1'b0) begin fails++; $display("FAIL busy_clksel k+%0d got=%b exp=0", i, clksel); end
      tests++; if (done !== (i == 12)) begin fails++; $display("FAIL busy_done k+%0d got=%b exp=%b", i, done, i == 12); end
    end
    tests++; if (drops != 3) begin fails++; $display("FAIL busy_drop_count got=%0d exp=3", drops); end
    tests++; if (switch_cnt !== 16'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_final got cnt=%0d busy=%b exp 2 0", switch_cnt, busy); end
    $display("[TB] request while busy: drops=%0d clksel=%b cnt=%0d", drops, clksel, switch_cnt);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_sel = 1'b0;
    for (int i = 1; i <= 12; i++) tick();
    tests++; if (done !== 1'b1 || req_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_done got done=%b ready=%b exp 1 1", done, req_ready); end
    tick();
    req_valid = 1'b0;
    tests++; if (clksel !== 1'b0 || busy !== 1'b1 || switch_cnt !== 16'd4) begin
      fails++; $display("FAIL b2b_accept got clksel=%b busy=%b cnt=%0d exp 0 1 4", clksel, busy, switch_cnt); end
    repeat (12) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    $display("[TB] back-to-back: clksel=%b cnt=%0d", clksel, switch_cnt);
  endtask

  task automatic test_auto();
    int toggles = 0;
    int drops = 0;
    logic prev;
    rst = 1'b1; tick(); rst = 1'b0;
    auto_en = 1'b1; req_valid = 1'b1;
    prev = clksel;
    for (int e = 0; e < 200; e++) begin
      req_sel = e[0];
      tick();
      if (drop === 1'b1) drops++;
      if (clksel !== prev) begin
        tests++; if (e != 15 + 28 * toggles) begin
          fails++; $display("FAIL auto_toggle_edge n=%0d got=%0d exp=%0d", toggles, e, 15 + 28 * toggles); end
        toggles++;
        prev = clksel;
      end
    end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL auto_ready got=%b exp=0", req_ready); end
    auto_en = 1'b0; req_valid = 1'b0;
    repeat (20) tick();
    tests++; if (toggles != 7) begin fails++; $display("FAIL auto_toggles got=%0d exp=7", toggles); end
    tests++; if (drops != 200) begin fails++; $display("FAIL auto_drops got=%0d exp=200", drops); end
    tests++; if (switch_cnt !== 16'd7 || clksel !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL auto_final got cnt=%0d clksel=%b busy=%b exp 7 1 0", switch_cnt, clksel, busy); end
    $display("[TB] auto mode: toggles=%0d drops=%0d cnt=%0d", toggles, drops, switch_cnt);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    tests++; if (clksel !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_pre got clksel=%b busy=%b exp 1 1", clksel, busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (clksel !== 1'b0 || busy !== 1'b0 || switch_cnt !== 16'd0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got clksel=%b busy=%b cnt=%0d ready=%b exp 0 0 0 1", clksel, busy, switch_cnt, req_ready); end
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    tests++; if (dones != 0) begin fails++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    tests++; if (clksel !== 1'b1 || busy !== 1'b1 || switch_cnt !== 16'd1) begin
      fails++; $display("FAIL mid_next got clksel=%b busy=%b cnt=%0d exp 1 1 1", clksel, busy, switch_cnt); end
    repeat (12) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL mid_next_done got=%b exp=1", done); end
    $display("[TB] reset mid-switch: clksel=%b cnt=%0d", clksel, switch_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_same_sel();
    test_busy_drop();
    test_back_to_back();
    test_auto();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
